// File: rtl/serial_sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor controller.
package serial_sub_ctrl_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_sub_ctrl_full_sub_bit.sv
// Gate-level half subtractor and the 1-bit full subtractor built from two of them.
module half_sub (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b;
  assign bout = ~a & b;

endmodule

module full_sub_bit (
  input  logic x_i,
  input  logic y_i,
  input  logic bin_i,
  output logic d_o,
  output logic bo_o
);

  logic d1, b1, b2;

  half_sub u_hs0 (
    .a    (x_i),
    .b    (y_i),
    .diff (d1),
    .bout (b1)
  );

  half_sub u_hs1 (
    .a    (d1),
    .b    (bin_i),
    .diff (d_o),
    .bout (b2)
  );

  assign bo_o = b1 | b2;

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full-subtract cell sequenced LSB first,
// with a start/busy/done handshake.
module serial_sub_ctrl
  import serial_sub_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned RES_W = WIDTH - 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [RES_W-1:0]   res_q, res_d;
  logic               borrow_q, borrow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic cell_d, cell_bo;

  full_sub_bit u_cell (
    .x_i   (a_sr_q[0]),
    .y_i   (b_sr_q[0]),
    .bin_i (borrow_q),
    .d_o   (cell_d),
    .bo_o  (cell_bo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and datapath; DONE accepts a new start exactly like IDLE.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_sr_d   = a;
          b_sr_d   = b;
          res_d    = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        // Result bits enter from the top so the LSB ends at bit 0.
        res_d    = (res_q >> 1) | (RES_W'(cell_d) << (RES_W - 1));
        borrow_d = cell_bo;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          diff_d  = {cell_d, res_q};
          bout_d  = cell_bo;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl: WIDTH=8 vectors and corner sequences,
// plus an exhaustive WIDTH=4 sweep.
module tb_serial_sub_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start4;
  logic [7:0] a8, b8;
  logic [3:0] a4, b4;
  logic       busy8, done8, bout8;
  logic [7:0] diff8;
  logic       busy4, done4, bout4;
  logic [3:0] diff4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_sub_ctrl #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .busy  (busy8),
    .done  (done8),
    .diff  (diff8),
    .bout  (bout8)
  );

  serial_sub_ctrl #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .busy  (busy4),
    .done  (done4),
    .diff  (diff4),
    .bout  (bout4)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_diff;
    logic       exp_bout;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; sample/drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=8 operation from IDLE with full handshake checks.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] ed, input logic eb, input string name);
    a8 = a; b8 = b; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk({name, " busy"}, 32'(busy8), 32'd1);
      chk({name, " no_done"}, 32'(done8), 32'd0);
      tick();
    end
    chk({name, " done"}, 32'(done8), 32'd1);
    chk({name, " busy_off"}, 32'(busy8), 32'd0);
    chk({name, " diff"}, 32'(diff8), 32'(ed));
    chk({name, " bout"}, 32'(bout8), 32'(eb));
    tick();
    chk({name, " done_pulse"}, 32'(done8), 32'd0);
  endtask

  initial begin
    int dones;
    int lat;

    vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
    vecs[3] = '{8'h80, 8'h7F, 8'h01, 1'b0};
    vecs[4] = '{8'h01, 8'h80, 8'h81, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[6] = '{8'h03, 8'h05, 8'hFE, 1'b1};

    rst = 1'b1; start8 = 1'b0; start4 = 1'b0;
    a8 = '0; b8 = '0; a4 = '0; b4 = '0;
    tick();
    tick();
    chk("reset busy", 32'(busy8), 32'd0);
    chk("reset done", 32'(done8), 32'd0);
    chk("reset diff", 32'(diff8), 32'd0);
    chk("reset bout", 32'(bout8), 32'd0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 7; v++)
      run_op8(vecs[v].a, vecs[v].b, vecs[v].exp_diff, vecs[v].exp_bout, $sformatf("vec%0d", v));

    // Start pulse mid-RUN is ignored.
    a8 = 8'h5A; b8 = 8'h3C; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin a8 = 8'h10; b8 = 8'h01; start8 = 1'b1; end
      else start8 = 1'b0;
      if (done8) dones++;
      tick();
    end
    start8 = 1'b0;
    chk("midrun diff", 32'(diff8), 32'h1E);
    chk("midrun bout", 32'(bout8), 32'd0);
    for (int i = 0; i < 12; i++) begin
      if (done8) dones++;
      tick();
    end
    chk("midrun one_done", 32'(dones), 32'd1);

    // Reset during the 4th RUN cycle discards the run.
    a8 = 8'h5A; b8 = 8'h3C; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    chk("rstmid busy_before", 32'(busy8), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid busy", 32'(busy8), 32'd0);
    chk("rstmid done", 32'(done8), 32'd0);
    chk("rstmid diff", 32'(diff8), 32'd0);
    chk("rstmid bout", 32'(bout8), 32'd0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8) dones++;
      tick();
    end
    chk("rstmid no_done", 32'(dones), 32'd0);
    run_op8(8'h5A, 8'h3C, 8'h1E, 1'b0, "after_rst");

    // start held across DONE: re-accepted, previous result held during RUN.
    a8 = 8'h5A; b8 = 8'h3C; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("b2b done1", 32'(done8), 32'd1);
    chk("b2b diff1", 32'(diff8), 32'h1E);
    a8 = 8'h03; b8 = 8'h05; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("b2b busy", 32'(busy8), 32'd1);
      chk("b2b diff_held", 32'(diff8), 32'h1E);
      tick();
    end
    chk("b2b done2", 32'(done8), 32'd1);
    chk("b2b diff2", 32'(diff8), 32'hFE);
    chk("b2b bout2", 32'(bout8), 32'd1);
    tick();

    // Exhaustive WIDTH=4 sweep with latency check.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        a4 = 4'(i); b4 = 4'(j); start4 = 1'b1;
        tick();
        start4 = 1'b0;
        lat = 0;
        while (!done4 && lat < 10) begin
          tick();
          lat++;
        end
        chk($sformatf("w4 %0d-%0d lat", i, j), 32'(lat), 32'd4);
        chk($sformatf("w4 %0d-%0d diff", i, j), 32'(diff4), 32'((i - j) & 15));
        chk($sformatf("w4 %0d-%0d bout", i, j), 32'(bout4), 32'(i < j));
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
